mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/cache_def.sv | 26 ++
 rtl/mem_line_ram.sv | 25 ++
 rtl/mem_ctrl.sv | 119 +++++++++++
 tb/tb_mem_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/cache_def.sv
// Shared cache/memory interface types and defaults for the line memory controller.
package cache_def;

    localparam int LINE_W         = 128;
    localparam int LINE_IDX_W_DEF = 10;
    localparam int LATENCY_DEF    = 4;

    typedef struct packed {
        logic [31:0]       addr;
        logic [LINE_W-1:0] data;
        logic              rw;
        logic              valid;
    } mem_req_type;

    typedef struct packed {
        logic [LINE_W-1:0] data;
        logic              ready;
    } mem_data_type;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } mem_state_t;

endpackage

// File: rtl/mem_line_ram.sv
// Backing store of 128-bit lines: synchronous write, asynchronous read, one shared index.
module mem_line_ram
    import cache_def::*;
#(
    parameter int IDX_W = LINE_IDX_W_DEF
) (
    input  logic              clk_i,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);

    // Contents are deliberately never reset; lines start at zero only from power-up state.
    logic [LINE_W-1:0] lines [2**IDX_W];

    always_ff @(posedge clk_i) begin
        if (we) begin
            lines[idx] <= wdata;
        end
    end

    assign rdata = lines[idx];

endmodule

// File: rtl/mem_ctrl.sv
// Fixed-latency line memory controller, one request outstanding at a time.
// Define MEM_CTRL_STATS_EN to build the completed read/write line counters.
module mem_ctrl
    import cache_def::*;
#(
    parameter int LATENCY    = LATENCY_DEF,
    parameter int LINE_IDX_W = LINE_IDX_W_DEF
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  mem_req_type  mem_req_i,
    output mem_data_type mem_data_o,
    output logic [31:0]  no_rd_o,
    output logic [31:0]  no_wr_o
);

    mem_state_t            state_q;
    logic [7:0]            cnt_q;
    logic [LINE_IDX_W-1:0] idx_q;
    logic                  rw_q;
    logic                  ready_q;
    logic [LINE_W-1:0]     wdata_q;
    logic [LINE_W-1:0]     rdata_q;
    logic [LINE_W-1:0]     ram_rdata;
    logic                  ram_we;
    logic                  unused_addr_bits;

    // Offset bits and bits above the index never select a line; the index wraps.
    assign unused_addr_bits = ^{mem_req_i.addr[31:LINE_IDX_W+4], mem_req_i.addr[3:0]};

    assign ram_we = (state_q == RESP) && rw_q;

    mem_line_ram #(
        .IDX_W(LINE_IDX_W)
    ) u_ram (
        .clk_i (clk_i),
        .we    (ram_we),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (mem_req_i.valid) begin
                        idx_q   <= mem_req_i.addr[LINE_IDX_W+3:4];
                        rw_q    <= mem_req_i.rw;
                        wdata_q <= mem_req_i.data;
                        cnt_q   <= 8'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                    end
                end
                RESP: begin
                    // Read data is captured so the output holds it once ready drops.
                    if (!rw_q) begin
                        rdata_q <= ram_rdata;
                    end
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_data_o.ready = ready_q;
    assign mem_data_o.data  = (ready_q && !rw_q) ? ram_rdata : rdata_q;

`ifdef MEM_CTRL_STATS_EN
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (state_q == RESP) begin
            if (rw_q) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end else begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
        end
    end

    assign no_rd_o = rd_cnt_q;
    assign no_wr_o = wr_cnt_q;
`else
    assign no_rd_o = '0;
    assign no_wr_o = '0;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl: default build plus a LATENCY=1 instance.
module tb_mem_ctrl;
    import cache_def::*;

    localparam int LAT = 4;

    logic         clk_i;
    logic         rst_ni;
    mem_req_type  req;
    mem_data_type rsp;
    logic [31:0]  no_rd;
    logic [31:0]  no_wr;
    mem_req_type  req1;
    mem_data_type rsp1;
    logic [31:0]  no_rd1;
    logic [31:0]  no_wr1;

    int vectors;
    int miscompares;

    localparam logic [127:0] LINE_D = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] LINE_A = 128'h0A0A0A0A_11112222_33334444_A5A5A5A5;
    localparam logic [127:0] LINE_B = 128'hBBBBBBBB_CCCCDDDD_EEEEFFFF_12345678;

    mem_ctrl #(.LATENCY(LAT), .LINE_IDX_W(10)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .mem_req_i(req),
        .mem_data_o(rsp), .no_rd_o(no_rd), .no_wr_o(no_wr)
    );

    mem_ctrl #(.LATENCY(1), .LINE_IDX_W(10)) u_dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .mem_req_i(req1),
        .mem_data_o(rsp1), .no_rd_o(no_rd1), .no_wr_o(no_wr1)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Counters only exist in the stats build; otherwise they must read zero.
    function automatic logic [127:0] exp_cnt(input int n);
`ifdef MEM_CTRL_STATS_EN
        return 128'(n);
`else
        return 128'(0 * n);
`endif
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction; inputs are scrambled after acceptance to prove they are ignored.
    task automatic run_txn(input string tag, input logic rw, input logic [31:0] addr,
                           input logic [127:0] wdata, input logic [127:0] exp_data);
        @(negedge clk_i);
        req = '{addr: addr, data: wdata, rw: rw, valid: 1'b1};
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk_i);
            if (c == 1) begin
                req = '{addr: ~addr, data: ~wdata, rw: ~rw, valid: 1'b0};
            end
            check($sformatf("%s_ready_c%0d", tag, c), 128'(rsp.ready), 128'(c == LAT));
            if (c == LAT) begin
                check($sformatf("%s_data", tag), rsp.data, exp_data);
            end
        end
        @(negedge clk_i);
        check($sformatf("%s_ready_after", tag), 128'(rsp.ready), 128'(0));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        req         = '0;
        req1        = '0;
        rst_ni      = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_ready", 128'(rsp.ready), 128'(0));
        check("rst_data", rsp.data, 128'(0));
        check("rst_no_rd", 128'(no_rd), 128'(0));
        check("rst_no_wr", 128'(no_wr), 128'(0));
        rst_ni = 1'b1;

        // Read of an untouched line returns zero at exactly cycle LAT.
        run_txn("rd10", 1'b0, 32'h0000_0010, 128'(0), 128'(0));
        check("rd10_no_rd", 128'(no_rd), exp_cnt(1));

        // Write holds the last read value on the output, then read back same line.
        run_txn("wr40", 1'b1, 32'h0000_0040, LINE_D, 128'(0));
        check("wr40_no_wr", 128'(no_wr), exp_cnt(1));
        run_txn("rd4c", 1'b0, 32'h0000_004C, 128'(0), LINE_D);
        check("rd4c_no_rd", 128'(no_rd), exp_cnt(2));
        check("rd4c_hold", rsp.data, LINE_D);

        // Back-to-back reads with valid held: ready at cycles 4, 9, 14 only.
        @(negedge clk_i);
        req = '{addr: 32'h0000_0040, data: 128'(0), rw: 1'b0, valid: 1'b1};
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk_i);
            check($sformatf("b2b_ready_c%0d", c), 128'(rsp.ready),
                  128'(c == 4 || c == 9 || c == 14));
            if (c == 4 || c == 9 || c == 14) begin
                check($sformatf("b2b_data_c%0d", c), rsp.data, LINE_D);
            end
            if (c == 14) begin
                req.valid = 1'b0;
            end
        end
        check("b2b_no_rd", 128'(no_rd), exp_cnt(5));

        // Index wraps modulo 1024 lines: 0x4020 aliases 0x20.
        run_txn("wr20", 1'b1, 32'h0000_0020, LINE_A, LINE_D);
        run_txn("rd4020", 1'b0, 32'h0000_4020, 128'(0), LINE_A);
        check("wrap_no_wr", 128'(no_wr), exp_cnt(2));
        check("wrap_no_rd", 128'(no_rd), exp_cnt(6));

        // Reset in the middle of a write discards it and clears counters.
        @(negedge clk_i);
        req = '{addr: 32'h0000_0080, data: LINE_B, rw: 1'b1, valid: 1'b1};
        @(negedge clk_i);
        req.valid = 1'b0;
        check("mid_ready_c1", 128'(rsp.ready), 128'(0));
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        check("mid_data", rsp.data, 128'(0));
        for (int c = 4; c <= 6; c++) begin
            @(negedge clk_i);
            check($sformatf("mid_ready_c%0d", c), 128'(rsp.ready), 128'(0));
        end
        check("mid_no_rd", 128'(no_rd), 128'(0));
        check("mid_no_wr", 128'(no_wr), 128'(0));
        run_txn("rd80", 1'b0, 32'h0000_0080, 128'(0), 128'(0));
        check("rd80_no_rd", 128'(no_rd), exp_cnt(1));

        // LATENCY=1 instance: ready the cycle right after acceptance.
        @(negedge clk_i);
        req1 = '{addr: 32'h0000_0040, data: 128'(0), rw: 1'b0, valid: 1'b1};
        check("lat1_ready_c0", 128'(rsp1.ready), 128'(0));
        @(negedge clk_i);
        req1.valid = 1'b0;
        check("lat1_ready_c1", 128'(rsp1.ready), 128'(1));
        check("lat1_data", rsp1.data, 128'(0));
        @(negedge clk_i);
        check("lat1_ready_c2", 128'(rsp1.ready), 128'(0));
        check("lat1_no_rd", 128'(no_rd1), exp_cnt(1));
        check("lat1_no_wr", 128'(no_wr1), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
